// File: rtl/frame_fill_pkg.sv
// Shared types and default geometry for the frame RAM write scheduler.
package frame_fill_pkg;

    localparam int WORD_W = 12;
    localparam int OFS_W  = 11;
    localparam int ADDR_W = 12;
    // One spare bit so a pointer can hold the region size itself (the "full" value).
    localparam int PTR_W  = OFS_W + 1;

    localparam int FAST_BURST_DEF = 64;
    localparam int SLOW_BURST_DEF = 32;
    localparam int FAST_WORDS_DEF = 1536;
    localparam int PAGE_WORDS_DEF = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FAST = 2'd1,
        SLOW = 2'd2
    } state_t;

endpackage

// File: rtl/frame_fill_chan.sv
// Per-channel fill bookkeeping: region pointer, burst counter, full and burst-done decode.
module frame_fill_chan
    import frame_fill_pkg::*;
#(
    parameter int BURST = FAST_BURST_DEF,
    parameter int WORDS = FAST_WORDS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             acc_i,
    output logic [PTR_W-1:0] ptr_o,
    output logic             full_o,
    output logic             last_o
);

    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign ptr_o  = ptr_q;
    assign full_o = (ptr_q == PTR_W'(WORDS));
    assign last_o = (cnt_q == CNT_W'(BURST - 1));

    // Next pointer/counter: a page flip restarts the region, an accept advances it.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (acc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Pointer and burst counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_fill_arb.sv
// Write-side scheduler for the ping-pong frame RAM: arbitrates fast/slow
// bursts into the page the serializer is not reading, restarting on each flip.
module frame_fill_arb
    import frame_fill_pkg::*;
#(
    parameter int FAST_BURST = FAST_BURST_DEF,
    parameter int SLOW_BURST = SLOW_BURST_DEF,
    parameter int FAST_WORDS = FAST_WORDS_DEF,
    parameter int PAGE_WORDS = PAGE_WORDS_DEF
) (
    input  logic              iClkOrb,
    input  logic              reset,
    input  logic              iSwitch,
    input  logic              iFastReq,
    input  logic              iFastVal,
    input  logic [WORD_W-1:0] iFastData,
    output logic              oFastGnt,
    output logic              oFastRdy,
    input  logic              iSlowReq,
    input  logic              iSlowVal,
    input  logic [WORD_W-1:0] iSlowData,
    output logic              oSlowGnt,
    output logic              oSlowRdy,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [WORD_W-1:0] oWrData,
    output logic              oWrPage,
    output logic              oFastFull,
    output logic              oSlowFull,
    output logic              oAbort,
    output logic              oUnderrun
);

    state_t            state_q;
    logic              sw_prev_q, last_fast_q;
    logic              fast_gnt_q, slow_gnt_q;
    logic              wr_en_q, wr_page_q, abort_q, under_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;

    logic              flip, fast_acc, slow_acc;
    logic              fast_last, slow_last, fast_elig, slow_elig;
    logic [PTR_W-1:0]  fast_ptr, slow_ptr;
    logic [OFS_W-1:0]  fast_ofs, slow_ofs;

    assign flip      = iSwitch ^ sw_prev_q;
    // Ready is withheld on the flip cycle so no word lands on a stale page.
    assign oFastRdy  = (state_q == FAST) & ~flip;
    assign oSlowRdy  = (state_q == SLOW) & ~flip;
    assign fast_acc  = iFastVal & oFastRdy;
    assign slow_acc  = iSlowVal & oSlowRdy;
    assign fast_elig = iFastReq & ~oFastFull;
    assign slow_elig = iSlowReq & ~oSlowFull;
    assign fast_ofs  = fast_ptr[OFS_W-1:0];
    assign slow_ofs  = OFS_W'(FAST_WORDS) + slow_ptr[OFS_W-1:0];

    frame_fill_chan #(.BURST(FAST_BURST), .WORDS(FAST_WORDS)) u_fast (
        .clk(iClkOrb), .reset(reset), .clr_i(flip), .acc_i(fast_acc),
        .ptr_o(fast_ptr), .full_o(oFastFull), .last_o(fast_last)
    );

    frame_fill_chan #(.BURST(SLOW_BURST), .WORDS(PAGE_WORDS - FAST_WORDS)) u_slow (
        .clk(iClkOrb), .reset(reset), .clr_i(flip), .acc_i(slow_acc),
        .ptr_o(slow_ptr), .full_o(oSlowFull), .last_o(slow_last)
    );

    // Burst FSM with round-robin between channels; a flip overrides everything.
    always_ff @(posedge iClkOrb) begin
        if (reset) begin
            state_q     <= IDLE;
            fast_gnt_q  <= 1'b0;
            slow_gnt_q  <= 1'b0;
            last_fast_q <= 1'b0;
        end else if (flip) begin
            state_q    <= IDLE;
            fast_gnt_q <= 1'b0;
            slow_gnt_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fast_elig && (!slow_elig || !last_fast_q)) begin
                        state_q    <= FAST;
                        fast_gnt_q <= 1'b1;
                    end else if (slow_elig) begin
                        state_q    <= SLOW;
                        slow_gnt_q <= 1'b1;
                    end
                end
                FAST: begin
                    if (fast_acc && fast_last) begin
                        state_q     <= IDLE;
                        fast_gnt_q  <= 1'b0;
                        last_fast_q <= 1'b1;
                    end
                end
                SLOW: begin
                    if (slow_acc && slow_last) begin
                        state_q     <= IDLE;
                        slow_gnt_q  <= 1'b0;
                        last_fast_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    fast_gnt_q <= 1'b0;
                    slow_gnt_q <= 1'b0;
                end
            endcase
        end
    end

    // Flip tracking, write register and status pulses.
    always_ff @(posedge iClkOrb) begin
        if (reset) begin
            sw_prev_q <= iSwitch;
            wr_page_q <= ~iSwitch;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            abort_q   <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            sw_prev_q <= iSwitch;
            abort_q   <= flip & (state_q != IDLE);
            under_q   <= flip & ~oFastFull;
            if (flip) wr_page_q <= ~iSwitch;
            wr_en_q <= fast_acc | slow_acc;
            if (fast_acc) begin
                wr_addr_q <= {wr_page_q, fast_ofs};
                wr_data_q <= iFastData;
            end else if (slow_acc) begin
                wr_addr_q <= {wr_page_q, slow_ofs};
                wr_data_q <= iSlowData;
            end
        end
    end

    assign oFastGnt  = fast_gnt_q;
    assign oSlowGnt  = slow_gnt_q;
    assign oWrEn     = wr_en_q;
    assign oWrAddr   = wr_addr_q;
    assign oWrData   = wr_data_q;
    assign oWrPage   = wr_page_q;
    assign oAbort    = abort_q;
    assign oUnderrun = under_q;

endmodule

// File: tb/tb_frame_fill_arb.sv
// Randomized bench for frame_fill_arb against a burst/word-count reference model.
module tb_frame_fill_arb;

    logic        clk = 1'b0;
    logic        rst, sw, fReq, fVal, sReq, sVal;
    logic [11:0] fData, sData;
    logic        fGnt, fRdy, sGnt, sRdy, wrEn, wrPage, fFull, sFull, abrt, undr;
    logic [11:0] wrAddr, wrData;

    always #5 clk = ~clk;

    frame_fill_arb dut (
        .iClkOrb(clk), .reset(rst), .iSwitch(sw),
        .iFastReq(fReq), .iFastVal(fVal), .iFastData(fData), .oFastGnt(fGnt), .oFastRdy(fRdy),
        .iSlowReq(sReq), .iSlowVal(sVal), .iSlowData(sData), .oSlowGnt(sGnt), .oSlowRdy(sRdy),
        .oWrEn(wrEn), .oWrAddr(wrAddr), .oWrData(wrData), .oWrPage(wrPage),
        .oFastFull(fFull), .oSlowFull(sFull), .oAbort(abrt), .oUnderrun(undr)
    );

    int nchk = 0, nerr = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: who owns the port, words left in the burst, words
    // written per region this page, and the write expected next cycle.
    int          m_owner;     // 0 none, 1 fast, 2 slow
    int          m_left;
    int          m_fastN, m_slowN;
    bit          m_lastFast, m_page, m_swPrev;
    bit          m_wr, m_abort, m_under;
    logic [11:0] m_addr, m_data;
    int          cov_ffull = 0, cov_sfull = 0, cov_abort = 0, cov_fwr = 0;

    localparam int FW = 1536, SW = 512, FB = 64, SB = 32;

    task automatic model_step();
        bit flip, fa, sa, fe, se;
        if (rst) begin
            m_page = ~sw; m_swPrev = sw; m_owner = 0; m_left = 0;
            m_fastN = 0; m_slowN = 0; m_lastFast = 0;
            m_wr = 0; m_abort = 0; m_under = 0; m_addr = '0; m_data = '0;
            return;
        end
        flip = (sw != m_swPrev);
        m_swPrev = sw;
        fa = (m_owner == 1) && !flip && fVal;
        sa = (m_owner == 2) && !flip && sVal;
        m_wr = fa || sa;
        if (fa) begin m_addr = {m_page, 11'(m_fastN)}; m_data = fData; end
        if (sa) begin m_addr = {m_page, 11'(FW + m_slowN)}; m_data = sData; end
        m_abort = flip && (m_owner != 0);
        m_under = flip && (m_fastN != FW);
        if (flip) begin
            m_page = ~sw; m_owner = 0; m_left = 0; m_fastN = 0; m_slowN = 0;
        end else if (m_owner == 0) begin
            fe = fReq && (m_fastN < FW);
            se = sReq && (m_slowN < SW);
            if (fe && (!se || !m_lastFast)) begin m_owner = 1; m_left = FB; end
            else if (se) begin m_owner = 2; m_left = SB; end
        end else if (fa) begin
            m_fastN++; m_left--;
            if (m_left == 0) begin m_owner = 0; m_lastFast = 1; end
        end else if (sa) begin
            m_slowN++; m_left--;
            if (m_left == 0) begin m_owner = 0; m_lastFast = 0; end
        end
    endtask

    task automatic check_all();
        bit noflip;
        noflip = (sw == m_swPrev);
        chk("fast_gnt", 32'(fGnt), 32'(m_owner == 1));
        chk("slow_gnt", 32'(sGnt), 32'(m_owner == 2));
        chk("fast_rdy", 32'(fRdy), 32'((m_owner == 1) && noflip));
        chk("slow_rdy", 32'(sRdy), 32'((m_owner == 2) && noflip));
        chk("wr_en", 32'(wrEn), 32'(m_wr));
        if (m_wr) begin
            chk("wr_addr", 32'(wrAddr), 32'(m_addr));
            chk("wr_data", 32'(wrData), 32'(m_data));
        end
        chk("wr_page", 32'(wrPage), 32'(m_page));
        chk("fast_full", 32'(fFull), 32'(m_fastN == FW));
        chk("slow_full", 32'(sFull), 32'(m_slowN == SW));
        chk("abort", 32'(abrt), 32'(m_abort));
        chk("underrun", 32'(undr), 32'(m_under));
        if (m_fastN == FW) cov_ffull++;
        if (m_slowN == SW) cov_sfull++;
        if (m_abort) cov_abort++;
        if (m_wr && m_addr == 12'h800) cov_fwr++;
    endtask

    initial begin
        rst = 1; sw = 0; fReq = 0; fVal = 0; sReq = 0; sVal = 0; fData = '0; sData = '0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            cyc = i;
            if (i < 3) begin
                rst = 1; sw = 0; fReq = 0; sReq = 0; fVal = 0; sVal = 0;
            end else if (i < 4500) begin
                // Long undisturbed page: both regions must fill completely.
                rst  = 0;
                fReq = ($urandom_range(0, 9) != 0);
                sReq = ($urandom_range(0, 1) != 0);
                fVal = ($urandom_range(0, 4) != 0);
                sVal = ($urandom_range(0, 4) != 0);
            end else begin
                // Flips, resets and sparse valids.
                rst  = ($urandom_range(0, 699) == 0);
                if ($urandom_range(0, 149) == 0) sw = ~sw;
                fReq = ($urandom_range(0, 9) < 7);
                sReq = ($urandom_range(0, 9) < 7);
                fVal = ($urandom_range(0, 9) < 6);
                sVal = ($urandom_range(0, 9) < 6);
            end
            fData = 12'($urandom);
            sData = 12'($urandom);
            #1;
            if (i > 0) check_all();
            model_step();
        end
        chk("cov_fast_full_seen", 32'(cov_ffull > 0), 32'd1);
        chk("cov_slow_full_seen", 32'(cov_sfull > 0), 32'd1);
        chk("cov_abort_seen", 32'(cov_abort > 0), 32'd1);
        chk("cov_first_wr_0x800", 32'(cov_fwr > 0), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/frame_fill_arb.md
Name: frame_fill_arb

Overview:
Write-side scheduler for the 2x2048x12 ping-pong frame RAM that the orbit serializer drains.
- Two word sources share the single RAM write port: a fast channel (sensor bursts) and a slow channel (slow telemetry).
- Writes always target the page the serializer is NOT reading. Each channel owns a fixed region of that page.
- The block tracks the serializer's page toggle, restarts the fill on every flip, and flags incomplete or aborted fills.

Parameters:
FAST_BURST, 64, words per fast grant
SLOW_BURST, 32, words per slow grant
FAST_WORDS, 1536, fast region size (offsets 0..FAST_WORDS-1); must be a multiple of FAST_BURST
PAGE_WORDS, 2048, page size; slow region is offsets FAST_WORDS..PAGE_WORDS-1 (512 words); must be a multiple of SLOW_BURST

Ports:
iClkOrb  in  1  block clock (orbit clock domain)
reset  in  1  synchronous, active-high reset
iSwitch  in  1  serializer read-page select (level; every toggle is a page flip)
iFastReq  in  1  fast source has a burst pending (level)
iFastVal  in  1  fast data valid
iFastData  in  12  fast data word
oFastGnt  out  1  fast burst granted
oFastRdy  out  1  fast word accepted this cycle when iFastVal=1
iSlowReq / iSlowVal / iSlowData / oSlowGnt / oSlowRdy  same widths and meaning, slow channel
oWrEn  out  1  RAM write strobe
oWrAddr  out  12  {page, 11-bit offset}
oWrData  out  12  RAM write data
oWrPage  out  1  current write page (= ~iSwitch after a flip)
oFastFull  out  1  fast region complete for this page
oSlowFull  out  1  slow region complete for this page
oAbort  out  1  one-cycle pulse: a page flip cut a burst short
oUnderrun  out  1  one-cycle pulse: a flip occurred with the fast region incomplete

Behaviour:
- Reset (synchronous, high): state IDLE; pointers, burst counters, all outputs and flags 0; lastFast=0; swPrev<=iSwitch; oWrPage<=~iSwitch. No flip is detected on the first cycle after reset.
- flip = (iSwitch != swPrev); swPrev is updated every cycle.
- FSM states:
  - IDLE: eligible channel = Req & ~Full.
    - If both are eligible, grant the channel not served last (lastFast=0 -> fast first).
    - If one is eligible, grant it.
    - The transition takes one cycle. oXGnt is registered and asserts with the state.
  - FAST / SLOW: oXRdy = (state==X) & ~flip, combinational.
    - accept = iXVal & oXRdy.
    - Each accept increments the burst counter.
    - On the accept with count==BURST-1: next state IDLE, Gnt drops next cycle, lastFast updated.
    - Val gaps hold the counter; there is no timeout.
  - A minimum of one IDLE cycle separates bursts.
- Write path (latency 1):
  - On accept, register oWrEn=1, oWrData=data, oWrAddr={oWrPage, base+ptr}, where base is 0 for fast and FAST_WORDS for slow.
  - The same accept increments ptr. oWrEn=0 otherwise.
- Full: oFastFull = (fastPtr==FAST_WORDS); oSlowFull = (slowPtr==PAGE_WORDS-FAST_WORDS). A full channel is never granted. A burst cannot cross region end because sizes are multiples.
- Flip cycle (takes priority over every other event that cycle):
  - state->IDLE; Gnt cleared.
  - Both ptrs and burst counters cleared; Full flags clear next cycle.
  - oWrPage <= ~iSwitch.
  - oAbort=1 if state was FAST or SLOW.
  - oUnderrun=1 if fastPtr!=FAST_WORDS.
  - A write registered from the previous cycle's accept still issues in the flip cycle, to the old page.
- Flip coincident with burst-completing accept: impossible, because Rdy=0 on the flip cycle.
- Request during flip cycle: arbitrated normally from IDLE on the following cycle.
- Reset mid-burst: everything returns to reset values on the next edge. No write is emitted after reset.

Decomposition:
- Package frame_fill_pkg:
  - state enum {IDLE, FAST, SLOW}
  - WORD_W=12, OFS_W=11, ADDR_W=12
  - default burst and region constants
- Sub-module frame_fill_chan, instantiated twice (fast, slow). Each instance holds the region pointer, burst counter, full flag and burst-done decode.
- Top holds the FSM, round-robin flag, flip detect and write register.

Test Plan:
- Reset with iSwitch=0, then fast req plus 64 back-to-back vals: oWrPage=1; writes at oWrAddr 0x800..0x83F; oFastGnt drops 1 cycle after the 64th accept; no oAbort.
- Fast and slow req asserted together from reset: fast 0x800..0x83F, then slow 0xE00..0xE1F, then fast 0x840..; at least one IDLE cycle between grants.
- 24 fast bursts: oFastFull=1; the 25th request is never granted; slow requests are still served up to 0xFFF, then oSlowFull=1.
- Toggle iSwitch after 10 words of a fast burst: oAbort and oUnderrun pulse for one cycle; oWrPage=0; the next fast burst writes 0x000..0x03F.
- iFastVal toggling 1,0,0,1: writes only on accepted cycles; addresses contiguous; burst ends after exactly 64 accepts.
- Assert reset mid slow burst (word 5): next cycle all outputs 0, no further oWrEn; the following slow burst restarts at offset 1536.
